// File: rtl/vending_ctrl.sv
// Vending machine controller: key-driven product/quantity selection, coin payment, vend and refund.
// Ports: clk/reset (async active-low); key_valid/key_code in; state_code, display_value,
//        vend_pulse/vend_product/vend_qty, refund_pulse, change_value out (all registered).
module vending_ctrl #(
    parameter int NUM_PRODUCTS = 5,
    parameter int PRICE_W      = 8,
    parameter int MAX_QTY      = 3,
    parameter logic [NUM_PRODUCTS*PRICE_W-1:0] PRICES = 40'h01_02_05_0A_06,
    parameter int TIMEOUT_CYC  = 1000,
    localparam int QTY_W = $clog2(MAX_QTY + 1),
    localparam int DW    = PRICE_W + QTY_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic [2:0]       state_code,
    output logic [DW-1:0]    display_value,
    output logic             vend_pulse,
    output logic [3:0]       vend_product,
    output logic [QTY_W-1:0] vend_qty,
    output logic             refund_pulse,
    output logic [DW-1:0]    change_value
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [3:0] K_OK      = 4'hF;
    localparam logic [3:0] K_CONFIRM = 4'hE;
    localparam logic [3:0] K_COLLECT = 4'hD;
    localparam logic [3:0] K_CANCEL  = 4'hC;
    localparam logic [3:0] K_QTY_UP  = 4'hB;
    localparam logic [3:0] K_QTY_DN  = 4'h0;
    localparam logic [3:0] K_COIN1   = 4'h8;
    localparam logic [3:0] K_COIN5   = 4'h9;
    localparam logic [3:0] K_COIN10  = 4'hA;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        PRICE   = 3'd2,
        QTY     = 3'd3,
        CONFIRM = 3'd4,
        PAY     = 3'd5,
        VEND    = 3'd6
    } state_t;

    state_t             state, state_nxt;
    logic [3:0]         product, product_nxt;
    logic [PRICE_W-1:0] price, price_nxt;
    logic [QTY_W-1:0]   qty, qty_nxt;
    logic [DW-1:0]      total, total_nxt;
    logic [DW-1:0]      credit, credit_nxt;
    logic [TMR_W-1:0]   timer, timer_nxt;

    logic [DW-1:0]      display_nxt;
    logic               vend_pulse_nxt;
    logic [3:0]         vend_product_nxt;
    logic [QTY_W-1:0]   vend_qty_nxt;
    logic               refund_pulse_nxt;
    logic [DW-1:0]      change_nxt;

    logic               abort;
    logic               timed_out;
    logic [3:0]         coin;
    logic [DW:0]        credit_sum;

    function automatic logic [PRICE_W-1:0] unit_price(input logic [3:0] k);
        logic [PRICE_W-1:0] p;
        p = '0;
        for (int i = 1; i <= NUM_PRODUCTS; i++) begin
            if (k == 4'(i)) p = PRICES[i*PRICE_W-1 -: PRICE_W];
        end
        return p;
    endfunction

    always_comb begin
        state_nxt        = state;
        product_nxt      = product;
        price_nxt        = price;
        qty_nxt          = qty;
        total_nxt        = total;
        credit_nxt       = credit;
        timer_nxt        = timer;
        vend_pulse_nxt   = 1'b0;
        refund_pulse_nxt = 1'b0;
        vend_product_nxt = vend_product;
        vend_qty_nxt     = vend_qty;
        change_nxt       = change_value;
        display_nxt      = '0;
        abort            = 1'b0;
        coin             = 4'd0;
        credit_sum       = '0;

        // A key in the expiry cycle wins, so expiry requires a keyless cycle.
        timed_out = !key_valid && (state inside {SELECT, PRICE, QTY, CONFIRM, PAY}) &&
                    (timer == TMR_W'(TIMEOUT_CYC - 1));

        case (state)
            IDLE: begin
                if (key_valid && key_code == K_OK) state_nxt = SELECT;
            end
            SELECT: begin
                if (key_valid) begin
                    if (key_code == K_CANCEL) begin
                        abort = 1'b1;
                    end else if (key_code != 4'd0 && key_code <= 4'(NUM_PRODUCTS)) begin
                        product_nxt = key_code;
                        price_nxt   = unit_price(key_code);
                        state_nxt   = PRICE;
                    end
                end
            end
            PRICE: begin
                if (key_valid) begin
                    if (key_code == K_CANCEL) begin
                        abort = 1'b1;
                    end else if (key_code == K_OK) begin
                        qty_nxt   = QTY_W'(1);
                        state_nxt = QTY;
                    end
                end
            end
            QTY: begin
                if (key_valid) begin
                    if (key_code == K_CANCEL) begin
                        abort = 1'b1;
                    end else if (key_code == K_QTY_UP) begin
                        if (qty < QTY_W'(MAX_QTY)) qty_nxt = qty + QTY_W'(1);
                    end else if (key_code == K_QTY_DN) begin
                        if (qty > QTY_W'(1)) qty_nxt = qty - QTY_W'(1);
                    end else if (key_code == K_OK) begin
                        total_nxt = DW'(price) * DW'(qty);
                        state_nxt = CONFIRM;
                    end
                end
            end
            CONFIRM: begin
                if (key_valid) begin
                    if (key_code == K_CANCEL) begin
                        abort = 1'b1;
                    end else if (key_code == K_CONFIRM) begin
                        credit_nxt = '0;
                        state_nxt  = PAY;
                    end
                end
            end
            PAY: begin
                if (key_valid) begin
                    case (key_code)
                        K_COIN1:  coin = 4'd1;
                        K_COIN5:  coin = 4'd5;
                        K_COIN10: coin = 4'd10;
                        default:  coin = 4'd0;
                    endcase
                    if (key_code == K_CANCEL) begin
                        abort = 1'b1;
                    end else if (key_code == K_OK) begin
                        if (credit >= total) begin
                            vend_pulse_nxt   = 1'b1;
                            vend_product_nxt = product;
                            vend_qty_nxt     = qty;
                            change_nxt       = credit - total;
                            state_nxt        = VEND;
                        end
                    end else if (coin != 4'd0) begin
                        credit_sum = {1'b0, credit} + (DW + 1)'(coin);
                        credit_nxt = credit_sum[DW] ? '1 : credit_sum[DW-1:0];
                    end
                end
            end
            VEND: begin
                if (key_valid && key_code == K_COLLECT) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (abort || timed_out) begin
            state_nxt = IDLE;
            if (credit != '0) begin
                refund_pulse_nxt = 1'b1;
                change_nxt       = credit;
            end
        end

        // Credit never survives a return to IDLE; any refund was taken above.
        if (state_nxt == IDLE) credit_nxt = '0;

        if (key_valid || state_nxt != state) timer_nxt = '0;
        else if (timer != '1)                timer_nxt = timer + TMR_W'(1);

        case (state_nxt)
            SELECT, PRICE: display_nxt = DW'(price_nxt);
            QTY:           display_nxt = DW'(qty_nxt);
            CONFIRM:       display_nxt = total_nxt;
            PAY:           display_nxt = credit_nxt;
            VEND:          display_nxt = change_nxt;
            default:       display_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            product       <= '0;
            price         <= '0;
            qty           <= '0;
            total         <= '0;
            credit        <= '0;
            timer         <= '0;
            display_value <= '0;
            vend_pulse    <= 1'b0;
            vend_product  <= '0;
            vend_qty      <= '0;
            refund_pulse  <= 1'b0;
            change_value  <= '0;
        end else begin
            state         <= state_nxt;
            product       <= product_nxt;
            price         <= price_nxt;
            qty           <= qty_nxt;
            total         <= total_nxt;
            credit        <= credit_nxt;
            timer         <= timer_nxt;
            display_value <= display_nxt;
            vend_pulse    <= vend_pulse_nxt;
            vend_product  <= vend_product_nxt;
            vend_qty      <= vend_qty_nxt;
            refund_pulse  <= refund_pulse_nxt;
            change_value  <= change_nxt;
        end
    end

    assign state_code = state;

endmodule

// File: tb/tb_vending_ctrl.sv
// Testbench for vending_ctrl: directed key sequences, a behavioural model compared every cycle,
// plus literal expectations for the key scenarios.
module tb_vending_ctrl;

    localparam int QW   = 2;
    localparam int DWT  = 10;
    localparam int TMO  = 1000;
    localparam int NP   = 5;
    localparam int MAXQ = 3;

    logic           clk;
    logic           reset;
    logic           key_valid;
    logic [3:0]     key_code;
    logic [2:0]     state_code;
    logic [DWT-1:0] display_value;
    logic           vend_pulse;
    logic [3:0]     vend_product;
    logic [QW-1:0]  vend_qty;
    logic           refund_pulse;
    logic [DWT-1:0] change_value;

    vending_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .state_code   (state_code),
        .display_value(display_value),
        .vend_pulse   (vend_pulse),
        .vend_product (vend_product),
        .vend_qty     (vend_qty),
        .refund_pulse (refund_pulse),
        .change_value (change_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 0;

    // Unit prices of products 1..5 as a machine owner would list them.
    int price_tbl [1:5] = '{6, 10, 5, 2, 1};

    // Machine as seen from the front panel.
    int m_state, m_prod, m_price, m_qty, m_total, m_credit, m_idle;
    int e_disp, e_vend, e_refund, e_change, e_vprod, e_vqty;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_state = 0; m_prod = 0; m_price = 0; m_qty = 0; m_total = 0; m_credit = 0; m_idle = 0;
        e_disp = 0; e_vend = 0; e_refund = 0; e_change = 0; e_vprod = 0; e_vqty = 0;
    endtask

    task automatic model_step(input bit kv, input int kc);
        int nxt;
        bit ab;
        nxt = m_state;
        ab = 0;
        e_vend = 0;
        e_refund = 0;
        if (kv) begin
            if (m_state == 0 && kc == 15) nxt = 1;
            else if (m_state == 1 && kc >= 1 && kc <= NP) begin
                m_prod = kc; m_price = price_tbl[kc]; nxt = 2;
            end else if (m_state == 2 && kc == 15) begin
                m_qty = 1; nxt = 3;
            end else if (m_state == 3 && kc == 11) m_qty = (m_qty < MAXQ) ? m_qty + 1 : MAXQ;
            else if (m_state == 3 && kc == 0) m_qty = (m_qty > 1) ? m_qty - 1 : 1;
            else if (m_state == 3 && kc == 15) begin
                m_total = m_price * m_qty; nxt = 4;
            end else if (m_state == 4 && kc == 14) begin
                m_credit = 0; nxt = 5;
            end else if (m_state == 5 && (kc == 8 || kc == 9 || kc == 10)) begin
                m_credit += (kc == 8) ? 1 : (kc == 9) ? 5 : 10;
                if (m_credit > (1 << DWT) - 1) m_credit = (1 << DWT) - 1;
            end else if (m_state == 5 && kc == 15 && m_credit >= m_total) begin
                e_vend = 1; e_vprod = m_prod; e_vqty = m_qty; e_change = m_credit - m_total; nxt = 6;
            end else if (m_state == 6 && kc == 13) nxt = 0;
            if (kc == 12 && m_state >= 1 && m_state <= 5) ab = 1;
        end else if (m_state >= 1 && m_state <= 5 && m_idle + 1 == TMO) begin
            ab = 1;
        end
        if (ab) begin
            if (m_credit > 0) begin
                e_refund = 1; e_change = m_credit;
            end
            nxt = 0;
        end
        if (nxt == 0) m_credit = 0;
        m_idle = (kv || nxt != m_state) ? 0 : m_idle + 1;
        m_state = nxt;
        case (m_state)
            1, 2:    e_disp = m_price;
            3:       e_disp = m_qty;
            4:       e_disp = m_total;
            5:       e_disp = m_credit;
            6:       e_disp = e_change;
            default: e_disp = 0;
        endcase
    endtask

    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            chk("state_code", int'(state_code), m_state);
            chk("display_value", int'(display_value), e_disp);
            chk("vend_pulse", int'(vend_pulse), e_vend);
            chk("refund_pulse", int'(refund_pulse), e_refund);
            if (e_vend != 0) begin
                chk("vend_product", int'(vend_product), e_vprod);
                chk("vend_qty", int'(vend_qty), e_vqty);
            end
            if (e_vend != 0 || e_refund != 0) chk("change_value", int'(change_value), e_change);
        end
    end

    task automatic key(input bit kv, input logic [3:0] kc);
        key_valid = kv;
        key_code  = kc;
        model_step(kv, int'(kc));
        @(posedge clk);
        #3;
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic press(input logic [3:0] kc);
        key(1'b1, kc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) key(1'b0, 4'h0);
    endtask

    initial begin
        reset = 1'b0;
        key_valid = 1'b0;
        key_code = 4'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        chk("rst_state", int'(state_code), 0);
        chk("rst_display", int'(display_value), 0);
        chk("rst_vend", int'(vend_pulse), 0);
        chk("rst_refund", int'(refund_pulse), 0);
        chk("rst_change", int'(change_value), 0);
        reset = 1'b1;
        chk_en = 1;

        // Full purchase: product 2 x3, pay 35, change 5.
        press(4'hF); press(4'h2); press(4'hF); press(4'hB); press(4'hB); press(4'hF);
        press(4'hE); press(4'hA); press(4'hA); press(4'hA); press(4'h9); press(4'hF);
        chk("buy_state", int'(state_code), 6);
        chk("buy_vend", int'(vend_pulse), 1);
        chk("buy_product", int'(vend_product), 2);
        chk("buy_qty", int'(vend_qty), 3);
        chk("buy_change", int'(change_value), 5);
        idle(1);
        chk("buy_vend_once", int'(vend_pulse), 0);
        chk("buy_display", int'(display_value), 5);
        press(4'hD);
        chk("collect_state", int'(state_code), 0);

        // Selection filtering and quantity saturation on product 3 (price 5).
        press(4'hF); press(4'h0); press(4'h6); press(4'h3); press(4'hF);
        press(4'h0);
        chk("qty_floor", int'(display_value), 1);
        press(4'hB); press(4'hB); press(4'hB); press(4'hB);
        chk("qty_ceiling", int'(display_value), 3);
        press(4'h0);
        chk("qty_dec", int'(display_value), 2);
        press(4'hF);
        chk("qty_total", int'(display_value), 10);
        press(4'hC);
        chk("cancel_nocredit_refund", int'(refund_pulse), 0);
        chk("cancel_state", int'(state_code), 0);

        // Insufficient credit then exact pay on product 1 (price 6).
        press(4'hF); press(4'h1); press(4'hF); press(4'hF); press(4'hE); press(4'h9); press(4'hF);
        chk("short_state", int'(state_code), 5);
        chk("short_display", int'(display_value), 5);
        press(4'h8); press(4'hF);
        chk("exact_state", int'(state_code), 6);
        chk("exact_change", int'(change_value), 0);
        press(4'hD);

        // Cancel with credit 7 refunds it.
        press(4'hF); press(4'h5); press(4'hF); press(4'hF); press(4'hE);
        press(4'h9); press(4'h8); press(4'h8); press(4'hC);
        chk("cancel_state2", int'(state_code), 0);
        chk("cancel_refund", int'(refund_pulse), 1);
        chk("cancel_change", int'(change_value), 7);
        idle(1);
        chk("cancel_refund_once", int'(refund_pulse), 0);

        // Timeout in PAY with credit 5; a key at the would-be expiry cycle wins.
        press(4'hF); press(4'h4); press(4'hF); press(4'hF); press(4'hE); press(4'h9);
        idle(TMO - 1);
        press(4'hD);
        chk("tmo_key_priority", int'(state_code), 5);
        idle(TMO - 1);
        chk("tmo_not_yet", int'(state_code), 5);
        idle(1);
        chk("tmo_state", int'(state_code), 0);
        chk("tmo_refund", int'(refund_pulse), 1);
        chk("tmo_change", int'(change_value), 5);

        // Asynchronous reset mid-PAY with credit 10.
        press(4'hF); press(4'h1); press(4'hF); press(4'hF); press(4'hE); press(4'hA);
        chk("pre_reset_credit", int'(display_value), 10);
        reset = 1'b0;
        model_reset();
        #1;
        chk("arst_state", int'(state_code), 0);
        chk("arst_display", int'(display_value), 0);
        chk("arst_refund", int'(refund_pulse), 0);
        chk("arst_vend", int'(vend_pulse), 0);
        chk("arst_change", int'(change_value), 0);
        chk("arst_product", int'(vend_product), 0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        press(4'hF); press(4'h7);
        chk("sel7_state", int'(state_code), 1);
        chk("sel7_display", int'(display_value), 0);
        press(4'hC);
        chk("sel7_cancel", int'(state_code), 0);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vending_ctrl.md
VENDING_CTRL -- requirements
Module: vending_ctrl

Interface
REQ-001 SHALL have parameter NUM_PRODUCTS, default 5, meaning number of selectable products (1..9).
REQ-002 SHALL have parameter PRICE_W, default 8, meaning width of one unit price.
REQ-003 SHALL have parameter MAX_QTY, default 3, meaning max quantity per vend (>=1); QTY_W = clog2(MAX_QTY+1), DW = PRICE_W+QTY_W (localparams).
REQ-004 SHALL have parameter PRICES, default 40'h01_02_05_0A_06, meaning packed unit prices; product k at bits [k*PRICE_W-1 -: PRICE_W] (default prices: p1=6, p2=10, p3=5, p4=2, p5=1).
REQ-005 SHALL have parameter TIMEOUT_CYC, default 1000, meaning idle-key cycles before abort.
REQ-006 SHALL have port clk  input  1  rising-edge clock.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port key_valid  input  1  one-cycle strobe, debounced key event.
REQ-009 SHALL have port key_code  input  4  key value, sampled only when key_valid=1.
REQ-010 SHALL have port state_code  output  3  current state encoding for the state display.
REQ-011 SHALL have port display_value  output  DW  value for the main display.
REQ-012 SHALL have port vend_pulse  output  1  one-cycle dispense strobe.
REQ-013 SHALL have port vend_product  output  4  product id, valid with vend_pulse.
REQ-014 SHALL have port vend_qty  output  QTY_W  quantity, valid with vend_pulse.
REQ-015 SHALL have port refund_pulse  output  1  one-cycle coin-return strobe.
REQ-016 SHALL have port change_value  output  DW  amount returned, valid with vend_pulse or refund_pulse.

Function
REQ-017 SHALL implement a fully registered FSM; all outputs driven from flops; no latches.
REQ-018 States/encodings: IDLE=0, SELECT=1, PRICE=2, QTY=3, CONFIRM=4, PAY=5, VEND=6; code 7 SHALL recover to IDLE next cycle.
REQ-019 Keys: F=OK, E=confirm, D=collect, C=cancel, B=qty+, 0=qty-, coins 8=+1, 9=+5, A=+10 (PAY only); key_valid=0 cycles SHALL cause no transition except timeout.
REQ-020 IDLE: F -> SELECT; display_value=0.
REQ-021 SELECT: key 1..NUM_PRODUCTS latches product and unit price, -> PRICE; key 0 or >NUM_PRODUCTS ignored; display_value=last latched price (0 after reset).
REQ-022 PRICE: display unit price; F -> QTY with qty=1.
REQ-023 QTY: B increments, 0 decrements, saturating at MAX_QTY and 1; display qty; F -> CONFIRM, registering total=price*qty (DW bits, exact).
REQ-024 CONFIRM: display total; E -> PAY with credit=0.
REQ-025 PAY: coin keys add to credit, saturating at 2^DW-1; display credit; F with credit>=total -> VEND; F with credit<total ignored.
REQ-026 VEND entry cycle: vend_pulse=1 exactly one cycle, vend_product/vend_qty set, change_value=credit-total; display change; D -> IDLE.
REQ-027 C in SELECT..PAY -> IDLE; if credit>0, refund_pulse=1 one cycle with change_value=credit; credit cleared.
REQ-028 Timeout counter SHALL clear on every key_valid and on state change; in states 1..5 reaching TIMEOUT_CYC -> IDLE with refund as REQ-027; VEND and IDLE never time out.
REQ-029 vend_pulse and refund_pulse SHALL never assert in the same cycle.
REQ-030 A key arriving in the same cycle as timeout expiry SHALL take priority; timeout ignored.

Reset
REQ-031 reset=0 SHALL asynchronously force state IDLE, credit/total/qty/price/timer 0, and all outputs 0, regardless of state.
REQ-032 Reset mid-PAY SHALL discard credit without refund_pulse.

Verification
REQ-033 F,2,F,B,B,F,E,A,A,A,9,F -> state_code 6, vend_pulse one cycle, vend_product=2, vend_qty=3, change_value=5.
REQ-034 F,3,F,B,B,B,B,0 (QTY) -> display_value 3 then 2; total 10 after F; qty never exceeds 3 or drops below 1.
REQ-035 In PAY total=6, keys 9 then F -> stays PAY, display 5; then 8,F -> VEND, change_value=0.
REQ-036 In PAY credit=7, key C -> IDLE next cycle, refund_pulse=1 one cycle, change_value=7.
REQ-037 In PAY credit=5, no keys for 1000 cycles -> IDLE, refund_pulse with change_value=5; key at cycle 999 restarts count.
REQ-038 reset=0 asynchronously mid-PAY, credit=10 -> all outputs 0 immediately, state_code 0, no refund_pulse; key 7 in SELECT ignored.
